// File: rtl/playback_sequencer.sv
// Sample playback controller: waits for codec config, then issues one RAM read per sample strobe
// under play/pause/stop/loop control and owns the power-of-two gain coefficient.
// Optional build macro PLAYBACK_MUTE_EN forces gain_coeff to zero outside PLAY.
module playback_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] ADDR_LAST = 16'hFFFF,
    parameter logic [23:0]       GAIN_DEF  = 24'h000400,
    parameter logic [23:0]       GAIN_MIN  = 24'h000040,
    parameter logic [23:0]       GAIN_MAX  = 24'h004000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_done,
    input  logic              sample_stb,
    input  logic              play_req,
    input  logic              stop_req,
    input  logic              loop_en,
    input  logic              gain_up,
    input  logic              gain_dn,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [23:0]       gain_coeff,
    output logic [1:0]        state,
    output logic              done
);

    typedef enum logic [1:0] {
        S_WAIT_CFG = 2'b00,
        S_IDLE     = 2'b01,
        S_PLAY     = 2'b10,
        S_PAUSE    = 2'b11
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              rd_en_nxt;
    logic              done_nxt;
    logic [23:0]       gain;
    logic [23:0]       gain_nxt;
    logic              rd_fire;
    logic              at_last;

    // A read happens only when no higher-priority request claims the cycle.
    assign rd_fire = (cur_state == S_PLAY) && cfg_done && !stop_req && !play_req && sample_stb;
    assign at_last = (ptr == ADDR_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state <= S_WAIT_CFG;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_WAIT_CFG: begin
                if (cfg_done) nxt_state = S_IDLE;
            end
            S_IDLE: begin
                if (!cfg_done)    nxt_state = S_WAIT_CFG;
                else if (play_req) nxt_state = S_PLAY;
            end
            S_PLAY: begin
                if (!cfg_done)                  nxt_state = S_WAIT_CFG;
                else if (stop_req)              nxt_state = S_IDLE;
                else if (play_req)              nxt_state = S_PAUSE;
                else if (rd_fire && at_last && !loop_en) nxt_state = S_IDLE;
            end
            S_PAUSE: begin
                if (!cfg_done)     nxt_state = S_WAIT_CFG;
                else if (stop_req) nxt_state = S_IDLE;
                else if (play_req) nxt_state = S_PLAY;
            end
            default: nxt_state = S_WAIT_CFG;
        endcase
    end

    always_comb begin
        ptr_nxt     = ptr;
        rd_addr_nxt = rd_addr;
        rd_en_nxt   = 1'b0;
        done_nxt    = 1'b0;
        if ((cur_state != S_WAIT_CFG) && !cfg_done) begin
            ptr_nxt = '0;
        end else if (((cur_state == S_PLAY) || (cur_state == S_PAUSE)) && stop_req) begin
            ptr_nxt = '0;
        end else if (rd_fire) begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = ptr;
            if (at_last) begin
                ptr_nxt  = '0;
                done_nxt = !loop_en;
            end else begin
                ptr_nxt = ptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b0;
            done    <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            rd_addr <= rd_addr_nxt;
            rd_en   <= rd_en_nxt;
            done    <= done_nxt;
        end
    end

    // Simultaneous up and down cancel; limits saturate.
    always_comb begin
        gain_nxt = gain;
        if (gain_up && !gain_dn && (gain < GAIN_MAX)) begin
            gain_nxt = gain << 1;
        end else if (gain_dn && !gain_up && (gain > GAIN_MIN)) begin
            gain_nxt = gain >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gain <= GAIN_DEF;
        end else begin
            gain <= gain_nxt;
        end
    end

`ifdef PLAYBACK_MUTE_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gain_coeff <= '0;
        end else begin
            gain_coeff <= (nxt_state == S_PLAY) ? gain_nxt : 24'd0;
        end
    end
`else
    assign gain_coeff = gain;
`endif

    assign state = cur_state;

endmodule
